// File: rtl/fp_pkg.sv
// Shared types and field helpers for the sequential single-precision add/subtract unit.
package fp_pkg;

    localparam int MAN_W   = 23;
    localparam int EXP_W   = 8;
    localparam int SIG_W   = MAN_W + 2;
    localparam int EXP_MAX = 255;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        PACK  = 3'd4,
        DONE  = 3'd5
    } state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } fp_fields_t;

    function automatic fp_fields_t fp_unpack(input logic [31:0] word);
        return fp_fields_t'(word);
    endfunction

    function automatic logic [31:0] fp_pack(input logic sign, input logic [EXP_W-1:0] exp,
                                            input logic [MAN_W-1:0] frac);
        return {sign, exp, frac};
    endfunction

endpackage

// File: rtl/fp_norm_step.sv
// One normalisation step: single right shift on carry-out, or one left shift toward the hidden bit.
module fp_norm_step #(
    parameter int SIG_W   = 25,
    parameter int EXP_W   = 8,
    parameter int EXP_MAX = 255
) (
    input  logic [SIG_W-1:0] sig_cur,
    input  logic [EXP_W-1:0] exp_cur,
    output logic [SIG_W-1:0] sig_next,
    output logic [EXP_W-1:0] exp_next,
    output logic             done,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);
    localparam logic [EXP_W:0]   EXP_LIM = (EXP_W+1)'(EXP_MAX);

    logic [EXP_W:0] exp_inc_s;

    assign exp_inc_s = {1'b0, exp_cur} + {{EXP_W{1'b0}}, 1'b1};

    // Finishing on the shift that lands the leading one keeps the step count at max(1,k).
    always_comb begin
        sig_next  = sig_cur;
        exp_next  = exp_cur;
        done      = 1'b0;
        overflow  = 1'b0;
        underflow = 1'b0;
        if (sig_cur[SIG_W-1]) begin
            sig_next = sig_cur >> 1;
            exp_next = exp_inc_s[EXP_W-1:0];
            done     = 1'b1;
            overflow = (exp_inc_s >= EXP_LIM);
        end else if (sig_cur[SIG_W-2]) begin
            done = 1'b1;
        end else if (exp_cur <= EXP_ONE) begin
            done      = 1'b1;
            underflow = 1'b1;
        end else begin
            sig_next = sig_cur << 1;
            exp_next = exp_cur - EXP_ONE;
            done     = sig_cur[SIG_W-3];
        end
    end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 single-precision add/subtract sequencer, truncating, denormals flushed.
// Optional Inf/NaN bypass is enabled by defining FP_SPECIAL_EN.
module fp_addsub_seq #(
    parameter int MAN_W = 23,
    parameter int EXP_W = 8,
    parameter int BIAS  = 127
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic        overflow
);
    import fp_pkg::*;

    localparam int SW      = MAN_W + 2;
    localparam int EXP_TOP = 2 * BIAS + 1;
    localparam logic [EXP_W-1:0] ALIGN_LIM = EXP_W'(SW);
    localparam logic [EXP_W-1:0] EXP_ONES  = {EXP_W{1'b1}};

    state_t state_r, state_s;

    fp_fields_t ra_s, rb_s, xa_s, xb_s;
    logic          swap_s;
    logic [SW-1:0] sig_a_s, sig_b_s, add_sum_s;
    logic          special_s;
    logic [31:0]   special_res_s;

    logic             sign_r, sub_r, zero_r, ovf_r, special_r;
    logic [EXP_W-1:0] exp_r, d_r;
    logic [SW-1:0]    big_r, small_r;
    logic [31:0]      special_res_r;

    logic [SW-1:0]    norm_sig_s;
    logic [EXP_W-1:0] norm_exp_s;
    logic             norm_done_s, norm_ovf_s, norm_under_s;

    logic        in_ready_s, out_valid_s;
    logic        in_ready_r, out_valid_r, zero_out_r, ovf_out_r;
    logic [31:0] result_r;

    assign ra_s = fp_unpack(a);
    assign rb_s = fp_unpack(b);

    // Flush exp==0 operands to +0, fold op into B's sign, and pick the larger magnitude.
    always_comb begin
        xa_s = ra_s;
        xb_s = rb_s;
        xb_s.sign = rb_s.sign ^ op;
        if (ra_s.exp == {EXP_W{1'b0}}) begin
            xa_s = 32'h0000_0000;
        end else begin
            xa_s = ra_s;
        end
        if (rb_s.exp == {EXP_W{1'b0}}) begin
            xb_s = 32'h0000_0000;
        end else begin
            xb_s.sign = rb_s.sign ^ op;
        end
        swap_s  = {xb_s.exp, xb_s.frac} > {xa_s.exp, xa_s.frac};
        sig_a_s = {1'b0, (xa_s.exp != {EXP_W{1'b0}}), xa_s.frac};
        sig_b_s = {1'b0, (xb_s.exp != {EXP_W{1'b0}}), xb_s.frac};
    end

`ifdef FP_SPECIAL_EN
    // Inf/NaN operands skip the arithmetic pipeline entirely.
    always_comb begin
        logic nan_a, nan_b, inf_a, inf_b;
        nan_a     = (ra_s.exp == EXP_ONES) && (ra_s.frac != {MAN_W{1'b0}});
        nan_b     = (rb_s.exp == EXP_ONES) && (rb_s.frac != {MAN_W{1'b0}});
        inf_a     = (ra_s.exp == EXP_ONES) && (ra_s.frac == {MAN_W{1'b0}});
        inf_b     = (rb_s.exp == EXP_ONES) && (rb_s.frac == {MAN_W{1'b0}});
        special_s = (ra_s.exp == EXP_ONES) || (rb_s.exp == EXP_ONES);
        if (nan_a || nan_b || (inf_a && inf_b && (ra_s.sign != xb_s.sign))) begin
            special_res_s = QNAN;
        end else if (inf_a) begin
            special_res_s = fp_pack(ra_s.sign, EXP_ONES, {MAN_W{1'b0}});
        end else begin
            special_res_s = fp_pack(xb_s.sign, EXP_ONES, {MAN_W{1'b0}});
        end
    end
`else
    // Without the special-value option every exponent is handled arithmetically.
    always_comb begin
        special_s     = 1'b0;
        special_res_s = 32'h0000_0000;
    end
`endif

    assign add_sum_s = sub_r ? (big_r - small_r) : (big_r + small_r);

    fp_norm_step #(
        .SIG_W   (SW),
        .EXP_W   (EXP_W),
        .EXP_MAX (EXP_TOP)
    ) u_norm (
        .sig_cur   (big_r),
        .exp_cur   (exp_r),
        .sig_next  (norm_sig_s),
        .exp_next  (norm_exp_s),
        .done      (norm_done_s),
        .overflow  (norm_ovf_s),
        .underflow (norm_under_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = special_s ? PACK : ALIGN;
                end else begin
                    state_s = IDLE;
                end
            end
            ALIGN: state_s = ADD;
            ADD:   state_s = NORM;
            NORM: begin
                if (zero_r || norm_done_s) begin
                    state_s = PACK;
                end else begin
                    state_s = NORM;
                end
            end
            PACK: state_s = DONE;
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Handshake outputs, computed from the next state so they are registered without lag.
    always_comb begin
        in_ready_s  = (state_s == IDLE);
        out_valid_s = (state_s == DONE);
    end

    // Handshake output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
        end
    end

    // Datapath: capture, align, add, normalise, pack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_r        <= 1'b0;
            sub_r         <= 1'b0;
            zero_r        <= 1'b0;
            ovf_r         <= 1'b0;
            special_r     <= 1'b0;
            exp_r         <= {EXP_W{1'b0}};
            d_r           <= {EXP_W{1'b0}};
            big_r         <= {SW{1'b0}};
            small_r       <= {SW{1'b0}};
            special_res_r <= 32'h0000_0000;
            result_r      <= 32'h0000_0000;
            zero_out_r    <= 1'b0;
            ovf_out_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        sub_r         <= xa_s.sign ^ xb_s.sign;
                        zero_r        <= 1'b0;
                        ovf_r         <= 1'b0;
                        special_r     <= special_s;
                        special_res_r <= special_res_s;
                        if (swap_s) begin
                            sign_r  <= xb_s.sign;
                            exp_r   <= xb_s.exp;
                            d_r     <= xb_s.exp - xa_s.exp;
                            big_r   <= sig_b_s;
                            small_r <= sig_a_s;
                        end else begin
                            sign_r  <= xa_s.sign;
                            exp_r   <= xa_s.exp;
                            d_r     <= xa_s.exp - xb_s.exp;
                            big_r   <= sig_a_s;
                            small_r <= sig_b_s;
                        end
                    end
                end
                ALIGN: begin
                    small_r <= (d_r >= ALIGN_LIM) ? {SW{1'b0}} : (small_r >> d_r);
                end
                ADD: begin
                    big_r  <= add_sum_s;
                    zero_r <= (add_sum_s == {SW{1'b0}});
                end
                NORM: begin
                    if (!zero_r) begin
                        big_r <= norm_sig_s;
                        exp_r <= norm_exp_s;
                        if (norm_ovf_s) begin
                            ovf_r <= 1'b1;
                        end
                        if (norm_under_s) begin
                            zero_r <= 1'b1;
                        end
                    end
                end
                PACK: begin
                    if (special_r) begin
                        result_r   <= special_res_r;
                        zero_out_r <= 1'b0;
                        ovf_out_r  <= 1'b0;
                    end else if (zero_r) begin
                        result_r   <= 32'h0000_0000;
                        zero_out_r <= 1'b1;
                        ovf_out_r  <= 1'b0;
                    end else if (ovf_r) begin
                        result_r   <= fp_pack(sign_r, EXP_ONES, {MAN_W{1'b0}});
                        zero_out_r <= 1'b0;
                        ovf_out_r  <= 1'b1;
                    end else begin
                        result_r   <= fp_pack(sign_r, exp_r, big_r[MAN_W-1:0]);
                        zero_out_r <= 1'b0;
                        ovf_out_r  <= 1'b0;
                    end
                end
                DONE: begin
                    result_r <= result_r;
                end
                default: begin
                    zero_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign zero      = zero_out_r;
    assign overflow  = ovf_out_r;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed self-checking bench for fp_addsub_seq; latency counts clock edges including the accept edge.
module tb_fp_addsub_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fp_addsub_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // One transaction from the #1-after-edge phase; hold>0 adds backpressure cycles.
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                          input logic top, input logic [31:0] eres, input logic ez,
                          input logic eo, input int elat, input int hold);
        int lat;
        logic [31:0] held;
        check({tag, " ready_before"}, 32'(in_ready), 32'd1);
        a = ta;
        b = tb;
        op = top;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 32'hDEAD_BEEF;
        b = 32'h1234_5678;
        op = ~top;
        lat = 1;
        check({tag, " busy_ready"}, 32'(in_ready), 32'd0);
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(elat));
        check({tag, " result"}, result, eres);
        check({tag, " zero"}, 32'(zero), 32'(ez));
        check({tag, " overflow"}, 32'(overflow), 32'(eo));
        held = eres;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
        end
        if (hold > 0) begin
            check({tag, " held_result"}, result, held);
            check({tag, " held_valid"}, 32'(out_valid), 32'd1);
            check({tag, " held_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " valid_after"}, 32'(out_valid), 32'd0);
        check({tag, " ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 32'h0000_0000;
        b         = 32'h0000_0000;
        op        = 1'b0;
        #12;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", result, 32'h0000_0000);
        check("reset zero", 32'(zero), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1 + 1 = 2, carry path, shortest latency
        run_op("one_plus_one", 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b0, 1'b0, 5, 0);
        // 1 - 1 = +0
        run_op("one_minus_one", 32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 5, 0);
        // exponent gap of 30: smaller operand vanishes
        run_op("far_align", 32'h3F80_0000, 32'h3080_0000, 1'b0, 32'h3F80_0000, 1'b0, 1'b0, 5, 0);
        // truncated B loses its lsb: diff is 2^-23, 23 left shifts
        run_op("max_norm", 32'h3F80_0000, 32'h3F7F_FFFF, 1'b1, 32'h3400_0000, 1'b0, 1'b0, 27, 0);
        // largest finite + largest finite overflows
        run_op("overflow", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 1'b0, 1'b1, 5, 0);
        // 1.25 - 1 = 0.25, two left shifts
        run_op("two_shifts", 32'h3FA0_0000, 32'h3F80_0000, 1'b1, 32'h3E80_0000, 1'b0, 1'b0, 6, 0);
        // 1 - 3 = -2, swap and sign from the larger operand
        run_op("swap_neg", 32'h3F80_0000, 32'h4040_0000, 1'b1, 32'hC000_0000, 1'b0, 1'b0, 5, 0);
        // denormal A flushed to zero
        run_op("denorm_flush", 32'h0040_0000, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 1'b0, 1'b0, 5, 0);
        // backpressure for 10 cycles, then the next pair follows immediately
        run_op("backpressure", 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b0, 1'b0, 5, 10);
        run_op("after_bp", 32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, 1'b0, 1'b0, 5, 0);

`ifdef FP_SPECIAL_EN
        run_op("inf_pass", 32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7F80_0000, 1'b0, 1'b0, 2, 0);
        run_op("inf_minus_inf", 32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 1'b0, 1'b0, 2, 0);
        run_op("neg_inf_b", 32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000, 1'b0, 1'b0, 2, 0);
`endif

        // reset pulse while in NORM aborts the transaction
        a = 32'h3F80_0000;
        b = 32'h3F7F_FFFF;
        op = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort result", result, 32'h0000_0000);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort no_valid", 32'(seen), 32'd0);
        check("abort idle_ready", 32'(in_ready), 32'd1);
        run_op("post_abort", 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b0, 1'b0, 5, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
